// File: rtl/alpha_recursion_ctrl.sv
// Forward (alpha) recursion sequencer: walks one trellis block, drives branch-metric reads,
// alpha-element valids and alpha-memory writes. Optional normalization pulses via ALPHA_NORM_EN.
module alpha_recursion_ctrl #(
  parameter int BITS        = 16,
  parameter int MAX_LEN     = 1024,
  parameter int ADDR_W      = 10,
  parameter int NORM_PERIOD = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   block_len,
  output logic              busy,
  output logic              done,
  output logic              bm_rd_en,
  output logic [ADDR_W-1:0] bm_rd_addr,
  output logic              elem_in_valid,
  output logic              alpha_init_sel,
  output logic              norm_pulse,
  output logic              alpha_wr_en,
  output logic [ADDR_W-1:0] alpha_wr_addr
);

  localparam bit CfgOk = (BITS > 0) && ((64'd1 << ADDR_W) >= 64'(MAX_LEN)) &&
                         (MAX_LEN > 0) && (NORM_PERIOD > 0);

  if (!CfgOk) begin : g_bad_cfg
    $error("alpha_recursion_ctrl: inconsistent parameters");
  end

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] rd_cnt_q;
  logic [ADDR_W-1:0] last_idx_q, last_idx_d;
  logic              s1_valid_q, s2_valid_q;
  logic [ADDR_W-1:0] s1_idx_q, s2_idx_q;

  // Oversized requests clamp to MAX_LEN; low-bit wrap of N-1 is exact for N in 1..2^ADDR_W.
  always_comb begin
    last_idx_d = block_len[ADDR_W-1:0] - ADDR_W'(1);
    if (block_len > (ADDR_W+1)'(MAX_LEN))
      last_idx_d = ADDR_W'(MAX_LEN - 1);
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    busy     = 1'b0;
    done     = 1'b0;
    bm_rd_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = (block_len == '0) ? DONE : RUN;
      end
      RUN: begin
        busy     = 1'b1;
        bm_rd_en = 1'b1;
        if (rd_cnt_q == last_idx_q) state_d = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (s2_valid_q && (s2_idx_q == last_idx_q)) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Read counter saturates at the last index so N = MAX_LEN never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt_q   <= '0;
      last_idx_q <= '0;
      s1_valid_q <= 1'b0;
      s1_idx_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_idx_q   <= '0;
    end else begin
      if ((state_q == IDLE) && start) begin
        rd_cnt_q   <= '0;
        last_idx_q <= last_idx_d;
      end else if ((state_q == RUN) && (rd_cnt_q != last_idx_q)) begin
        rd_cnt_q <= rd_cnt_q + ADDR_W'(1);
      end
      s1_valid_q <= bm_rd_en;
      s1_idx_q   <= rd_cnt_q;
      s2_valid_q <= s1_valid_q;
      s2_idx_q   <= s1_idx_q;
    end
  end

  assign bm_rd_addr     = bm_rd_en ? rd_cnt_q : '0;
  assign elem_in_valid  = s1_valid_q;
  assign alpha_init_sel = s1_valid_q && (s1_idx_q == '0);
  assign alpha_wr_en    = s2_valid_q;
  assign alpha_wr_addr  = s2_valid_q ? s2_idx_q : '0;

`ifdef ALPHA_NORM_EN
  localparam int NW = (NORM_PERIOD > 1) ? $clog2(NORM_PERIOD) : 1;

  logic [NW-1:0] norm_cnt_q;
  logic          s1_norm_q;

  // Step-index modulo counter, restarted each block, aligned to stage 1 like elem_in_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      norm_cnt_q <= '0;
      s1_norm_q  <= 1'b0;
    end else begin
      if (state_q == IDLE)
        norm_cnt_q <= '0;
      else if (bm_rd_en)
        norm_cnt_q <= (norm_cnt_q == NW'(NORM_PERIOD - 1)) ? '0 : norm_cnt_q + NW'(1);
      s1_norm_q <= bm_rd_en && (norm_cnt_q == NW'(NORM_PERIOD - 1));
    end
  end

  assign norm_pulse = s1_valid_q & s1_norm_q;
`else
  assign norm_pulse = 1'b0;
`endif

endmodule

// File: doc/alpha_recursion_ctrl.md
# alpha_recursion_ctrl

Sequencer for the forward (alpha) recursion of the max-product turbo decoder. It walks one trellis block of N steps and drives the branch-metric memory read port. It also steers the alpha-element array's previous-alpha mux (initial vector or feedback) and generates the alpha-memory write strobe and address. The controller sits between the branch-metric buffer, the array of per-state alpha elements (1-cycle registered latency), and the alpha memory consumed later by the LLR stage.

## Interface
- BITS, 16: metric width, passed through to the surrounding datapath; controller carries no metric data.
- MAX_LEN, 1024: maximum trellis steps per block.
- ADDR_W, 10: address width; must satisfy 2^ADDR_W >= MAX_LEN.
- NORM_PERIOD, 8: steps between normalization pulses (used only with ALPHA_NORM_EN).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle block request; sampled only in IDLE.
- block_len  in  ADDR_W+1  step count N (0..MAX_LEN), sampled with start.
- busy  out  1  high from first RUN cycle through last alpha write.
- done  out  1  one-cycle pulse after last write.
- bm_rd_en  out  1  branch-metric memory read strobe (memory has 1-cycle read latency).
- bm_rd_addr  out  ADDR_W  step index being read.
- elem_in_valid  out  1  in_valid to every alpha element.
- alpha_init_sel  out  1  1 = previous-alpha mux selects initial vector (state 0 = 0, others = most-negative), 0 = element feedback; qualified by elem_in_valid.
- norm_pulse  out  1  normalize request to element array, coincident with elem_in_valid.
- alpha_wr_en  out  1  alpha memory write strobe (data = element outputs).
- alpha_wr_addr  out  ADDR_W  write address; alpha_k+1 stored at address k.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE: all outputs 0. On start with block_len >= 1: latch N, clear read counter, go to RUN. On start with block_len = 0: go directly to DONE. Values of block_len above MAX_LEN are clamped to MAX_LEN.
- RUN: bm_rd_en = 1 and bm_rd_addr = j for j = 0..N-1, one per cycle. After issuing j = N-1, go to DRAIN.
- Two-stage internal valid pipeline:
  - Stage 1 (read delayed by 1): elem_in_valid, alpha_init_sel = (index == 0).
  - Stage 2 (delayed by 2): alpha_wr_en, alpha_wr_addr = index.
- DRAIN: wait until the stage-2 valid for index N-1 has issued, then go to DONE.
- DONE: done = 1 for one cycle, then IDLE.
- busy = (state == RUN or state == DRAIN).
- start outside IDLE is ignored; it is neither queued nor does it alter the running block.
- Reset values: state IDLE, every output 0, counters 0, pipeline valids cleared.
- rst mid-block: abort on the next edge. No further reads, writes, or done. Partial alpha memory contents are undefined to consumers.

## Timing
- start sampled at edge of cycle s. Read j is at cycle s+1+j. elem_in_valid for j is at s+2+j. alpha write of address j is at s+3+j.
- Throughput: one trellis step per clock; the element's registered output in cycle s+2+j is the feedback for step j+1.
- busy spans cycles s+1..s+2+N. done is at cycle s+3+N with busy low. The earliest accepted next start is at cycle s+4+N.
- N = 0: done at cycle s+1, no reads or writes, busy never asserted.
- N = 1: one read, one elem_in_valid with alpha_init_sel = 1, one write to address 0.
- N = MAX_LEN: last write to address MAX_LEN-1; the counters do not wrap.

## Configuration
- ALPHA_NORM_EN defined: norm_pulse = 1 together with elem_in_valid for every step index k with k mod NORM_PERIOD == NORM_PERIOD-1. The step counter resets per block.
- ALPHA_NORM_EN undefined: norm_pulse is tied to 0 and the modulo counter is not built. All other behaviour and timing are identical.

## Test plan
- Reset then start with N = 4: reads at addresses 0..3 on cycles s+1..s+4. elem_in_valid on s+2..s+5 with alpha_init_sel only on s+2. Writes at addresses 0..3 on s+3..s+6. done on s+7.
- N = 0: done at s+1; bm_rd_en, elem_in_valid and alpha_wr_en never asserted.
- N = 1024 back-to-back with a start at the earliest legal cycle: 1024 contiguous writes, last address 1023. Second block starts at s+1028 with alpha_init_sel reasserted.
- start pulsed while busy (N = 8 in flight, second start at s+3 with N = 2): ignored. Exactly 8 writes and one done.
- rst asserted at s+3 of an N = 16 block: from the next cycle all outputs are 0, no done, and the FSM is in IDLE. A new start with N = 2 then runs normally.
- With ALPHA_NORM_EN and NORM_PERIOD = 8, N = 20: norm_pulse at steps 7 and 15 only (cycles s+9, s+17). Without the macro, norm_pulse stays 0.
